// File: rtl/dds_interp_sequencer.sv
// ---------------------------------------------------------------------------
// dds_interp_sequencer
//
// Feeds the DDS sine interpolator. It fetches samples from the recursive
// sine oscillator, keeps the Y[n-1]/Y[n-2] pair, paces the segment reload
// strobe, and applies the interpolation mode. The oscillator interface
// allows one outstanding request at a time. In RUN a single-entry prefetch
// buffer holds the next sample.
//
// Segment length P per mode: 0 -> 1, 1 -> 10, 2 -> 100, 3 -> 1000,
// 4..7 -> 1.
//
// Ports
//   Fg_CLK, Fg_RESETn     clock; asynchronous active-low reset
//   CfgMode[2:0]          requested mode, sampled every cycle into a pending reg
//   CfgStart, CfgStop     one-cycle control pulses (stop wins on collision)
//   OscReq                one-cycle request for the next oscillator sample
//   OscValid, OscData     response strobe and sample
//   out_1                 Y[n-1], the newer sample
//   out_2                 Y[n-2], the older sample and the segment start
//   DDSMode[2:0]          mode applied to the interpolator
//   DDSEnable             interpolator reload strobe
//   Busy                  high in PRIME, RUN and STOPPING
//   Underrun              sticky; set when a boundary finds no sample
// ---------------------------------------------------------------------------
module dds_interp_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10
) (
  input  logic              Fg_CLK,
  input  logic              Fg_RESETn,
  input  logic [2:0]        CfgMode,
  input  logic              CfgStart,
  input  logic              CfgStop,
  output logic              OscReq,
  input  logic              OscValid,
  input  logic [DATA_W-1:0] OscData,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [2:0]        DDSMode,
  output logic              DDSEnable,
  output logic              Busy,
  output logic              Underrun
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, STOPPING} state_t;

  // Final count of a segment: P-1 for the given mode.
  function automatic logic [CNT_W-1:0] last_step(input logic [2:0] mode);
    case (mode)
      3'd1:    last_step = CNT_W'(9);
      3'd2:    last_step = CNT_W'(99);
      3'd3:    last_step = CNT_W'(999);
      default: last_step = '0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        pend_mode_q, pend_mode_d;
  logic [2:0]        mode_q, mode_d;
  logic [DATA_W-1:0] out_1_q, out_1_d;
  logic [DATA_W-1:0] out_2_q, out_2_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              pending_q, pending_d;   // request outstanding
  logic              primed_q, primed_d;     // first PRIME sample is in out_1
  logic              osc_req_q, osc_req_d;
  logic              enable_q, enable_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;

  logic accept;
  logic at_boundary;
  logic shift;

  // A response counts only if it answers the request we have outstanding.
  assign accept      = OscValid && pending_q;
  assign at_boundary = (cnt_q == last_step(mode_q));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_mode_d = CfgMode;
    mode_d      = mode_q;
    out_1_d     = out_1_q;
    out_2_d     = out_2_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    pending_d   = pending_q && !accept;
    primed_d    = primed_q;
    underrun_d  = underrun_q;
    shift       = 1'b0;

    case (state_q)
      IDLE: begin
        // A sample that arrives here answers an old request and is dropped.
        if (CfgStart && !CfgStop) begin
          state_d    = PRIME;
          underrun_d = 1'b0;
          mode_d     = CfgMode;
          cnt_d      = '0;
          buf_full_d = 1'b0;
          primed_d   = 1'b0;
        end
      end
      PRIME: begin
        if (CfgStop) begin
          state_d = IDLE;
        end else if (accept) begin
          if (!primed_q) begin
            out_1_d  = OscData;
            primed_d = 1'b1;
          end else begin
            out_2_d = out_1_q;
            out_1_d = OscData;
            state_d = RUN;
            cnt_d   = '0;
            shift   = 1'b1;
          end
        end
      end
      RUN, STOPPING: begin
        if (at_boundary) begin
          // Start the next segment. With no sample ready, the segment is flat.
          out_2_d = out_1_q;
          if (buf_full_q) begin
            out_1_d    = buf_q;
            buf_full_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
          end
          mode_d = pend_mode_q;
          cnt_d  = '0;
          shift  = 1'b1;
          if (state_q == STOPPING || CfgStop) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (state_q == RUN && CfgStop) state_d = STOPPING;
        end
        // A request is only issued while the buffer is empty, so the buffer
        // always has room for the answer.
        if (accept) begin
          buf_d      = OscData;
          buf_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // In IDLE and PRIME the interpolator is held on out_2.
    enable_d  = (state_d == IDLE) || (state_d == PRIME) || shift;
    busy_d    = (state_d != IDLE);
    osc_req_d = ((state_d == PRIME) || (state_d == RUN)) && !buf_full_d && !pending_d;
    if (osc_req_d) pending_d = 1'b1;
  end

  // NOTE: buf_q and the sample pair are reset along with the control
  // state, so no X can leak onto out_1/out_2 after reset.
  always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
    if (!Fg_RESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_mode_q <= '0;
      mode_q      <= '0;
      out_1_q     <= '0;
      out_2_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      pending_q   <= 1'b0;
      primed_q    <= 1'b0;
      osc_req_q   <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all flops update together from
      // the values they held before the edge.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_mode_q <= pend_mode_d;
      mode_q      <= mode_d;
      out_1_q     <= out_1_d;
      out_2_q     <= out_2_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      pending_q   <= pending_d;
      primed_q    <= primed_d;
      osc_req_q   <= osc_req_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign OscReq    = osc_req_q;
  assign out_1     = out_1_q;
  assign out_2     = out_2_q;
  assign DDSMode   = mode_q;
  assign DDSEnable = enable_q;
  assign Busy      = busy_q;
  assign Underrun  = underrun_q;

endmodule
